// File: rtl/dlfloat_dot_sequencer_if.sv
// ---------------------------------------------------------------------------
// dlfloat_dot_sequencer_if
//   Bundles the signals around the dot-product sequencer: the 8-bit
//   header/operand input stream, the 8-bit result output stream, the
//   issue bus to the shared DLFloat16 MAC, and the status flags.
//
//   master : the sequencer's view (drives in_ready, out_*, mac_a/b/en/clr,
//            busy, err; receives in_data/in_valid, out_ready, mac_acc)
//   slave  : the surrounding logic's view (pin wrappers + MAC)
// ---------------------------------------------------------------------------
interface dlfloat_dot_sequencer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_en;
    logic        mac_clr;
    logic [15:0] mac_acc;
    logic        busy;
    logic        err;

    modport master (
        input  in_data, in_valid, out_ready, mac_acc,
        output in_ready, out_data, out_valid, mac_a, mac_b, mac_en, mac_clr,
               busy, err
    );

    modport slave (
        output in_data, in_valid, out_ready, mac_acc,
        input  in_ready, out_data, out_valid, mac_a, mac_b, mac_en, mac_clr,
               busy, err
    );
endinterface

// File: rtl/dlfloat_dot_sequencer.sv
// ---------------------------------------------------------------------------
// dlfloat_dot_sequencer
//   Byte-serial controller that runs a shared DLFloat16 MAC through an
//   N-element dot product. A length byte N is followed by N groups of four
//   operand bytes (A hi, A lo, B hi, B lo). Each pair is issued with a
//   one-cycle mac_en; the first pair of a vector also raises mac_clr. After
//   MAC_LAT cycles of drain the accumulator is captured and returned as two
//   bytes, MSB first. N=0 returns 16'h0000 without touching the MAC.
//
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset (aborts any operation)
//     bus    : dlfloat_dot_sequencer_if.master (streams, MAC bus, busy, err)
// ---------------------------------------------------------------------------
module dlfloat_dot_sequencer #(
    parameter int MAC_LAT = 2,
    parameter int LEN_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dlfloat_dot_sequencer_if.master   bus
);

    localparam int DCW = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_SEND_HI, S_SEND_LO
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_first;
    logic [1:0]         r_byte_idx;
    logic [DCW-1:0]     r_drain_cnt;
    logic [15:0]        r_result;
    logic [15:0]        r_mac_a;
    logic [15:0]        r_mac_b;
    logic               r_err;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_mac_en;
    logic               w_in_accept;
    logic [LEN_W-1:0]   w_hdr;

    assign w_in_accept = bus.in_valid && w_in_ready;
    assign w_hdr       = LEN_W'(bus.in_data);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_mac_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (w_in_accept)
                    w_next_state = (w_hdr == '0) ? S_SEND_HI : S_LOAD;
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (w_in_accept && r_byte_idx == 2'd3)
                    w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                w_mac_en     = 1'b1;
                w_next_state = (r_remaining == LEN_W'(1)) ? S_DRAIN : S_LOAD;
            end
            S_DRAIN: begin
                if (r_drain_cnt == DCW'(1))
                    w_next_state = S_SEND_HI;
            end
            S_SEND_HI: begin
                w_out_valid = 1'b1;
                if (bus.out_ready)
                    w_next_state = S_SEND_LO;
            end
            S_SEND_LO: begin
                w_out_valid = 1'b1;
                if (bus.out_ready)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand assembly, counters, result capture, sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_byte_idx  <= '0;
            r_drain_cnt <= '0;
            r_result    <= '0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_accept) begin
                        r_err <= 1'b0;
                        if (w_hdr != '0) begin
                            r_remaining <= w_hdr;
                            r_first     <= 1'b1;
                            r_byte_idx  <= '0;
                        end else begin
                            r_result <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_in_accept) begin
                        case (r_byte_idx)
                            2'd0: r_mac_a[15:8] <= bus.in_data;
                            2'd1: r_mac_a[7:0]  <= bus.in_data;
                            2'd2: r_mac_b[15:8] <= bus.in_data;
                            default: r_mac_b[7:0] <= bus.in_data;
                        endcase
                        // Two-bit index wraps 3 -> 0 on the fourth byte.
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_ISSUE: begin
                    // All-ones is the "bad operand" marker; still issued.
                    if (r_mac_a == 16'hFFFF || r_mac_b == 16'hFFFF)
                        r_err <= 1'b1;
                    r_first     <= 1'b0;
                    r_remaining <= r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1))
                        r_drain_cnt <= DCW'(MAC_LAT);
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt - DCW'(1);
                    // Last drain cycle is MAC_LAT cycles after the final mac_en.
                    if (r_drain_cnt == DCW'(1))
                        r_result <= bus.mac_acc;
                end
                default: ;
            endcase
        end
    end

    // in_ready is decoded from IDLE/LOAD; gating it with rst_n keeps every
    // output low while reset is held.
    assign bus.in_ready  = w_in_ready && rst_n;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = !w_out_valid           ? 8'h00          :
                           (r_state == S_SEND_LO) ? r_result[7:0]  :
                                                    r_result[15:8];
    assign bus.mac_a     = r_mac_a;
    assign bus.mac_b     = r_mac_b;
    assign bus.mac_en    = w_mac_en;
    assign bus.mac_clr   = w_mac_en && r_first;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.err       = r_err;

endmodule

// File: tb/tb_dlfloat_dot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dlfloat_dot_sequencer
//   Drives length/operand bytes with random gaps, models the MAC as a
//   real-arithmetic DLFloat16 accumulator with MAC_LAT cycles of latency,
//   and compares issued pairs, clear strobes, result bytes, err and the
//   output-hold rules against expectations computed from the operand lists.
// ---------------------------------------------------------------------------
module tb_dlfloat_dot_sequencer;

    localparam int MAC_LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dlfloat_dot_sequencer_if bus();

    dlfloat_dot_sequencer #(.MAC_LAT(MAC_LAT), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        clr;
    } pair_t;

    pair_t       exp_q[$];
    logic [15:0] vec_a[16];
    logic [15:0] vec_b[16];
    logic [15:0] mac_pipe[MAC_LAT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- DLFloat16 arithmetic (bench MAC) ----------------
    function automatic real to_real(input logic [15:0] v);
        int  e;
        real r;
        e = int'(v[14:9]);
        if (v[14:0] == 15'd0 || e == 63) return 0.0;
        r = (1.0 + real'(v[8:0]) / 512.0) * (2.0 ** (e - 31));
        return v[15] ? -r : r;
    endfunction

    function automatic logic [15:0] from_real(input real x);
        logic s;
        int   e;
        int   m;
        s = (x < 0.0);
        if (s) x = -x;
        if (x == 0.0) return 16'h0000;
        e = 31;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        if (e < 1)  return 16'h0000;
        if (e > 62) return {s, 6'd62, 9'h1FF};
        m = $rtoi((x - 1.0) * 512.0);
        return {s, 6'(e), 9'(m)};
    endfunction

    function automatic logic [15:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] acc, input logic clr);
        return from_real(to_real(a) * to_real(b) + (clr ? 0.0 : to_real(acc)));
    endfunction

    // MAC: pipe[0] is the live accumulator, later stages add latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAC_LAT; i++) mac_pipe[i] <= 16'h0000;
        end else begin
            if (bus.mac_en)
                mac_pipe[0] <= mac_fn(bus.mac_a, bus.mac_b, mac_pipe[0], bus.mac_clr);
            for (int i = 1; i < MAC_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
        end
    end
    assign bus.mac_acc = mac_pipe[MAC_LAT-1];

    // ---------------- per-cycle compare process ----------------
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    pair_t      mon_p;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.mac_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mac_en", 32'd1, 32'd0);
                end else begin
                    mon_p = exp_q.pop_front();
                    check("mac_a", bus.mac_a, mon_p.a);
                    check("mac_b", bus.mac_b, mon_p.b);
                    check("mac_clr", bus.mac_clr, mon_p.clr);
                end
            end else if (bus.mac_clr) begin
                check("clr_without_en", 32'd1, 32'd0);
            end
            if (bus.out_valid) check("in_ready_in_send", bus.in_ready, 32'd0);
            if (prev_hold) begin
                check("out_valid_held", bus.out_valid, 32'd1);
                check("out_data_stable", bus.out_data, prev_data);
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    // ---------------- stimulus tasks (entered/left at posedge+1) -------
    task automatic send_byte(input logic [7:0] d, input bit gaps);
        int budget;
        bit acc;
        if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        budget = 0;
        do begin
            @(negedge clk); acc = bus.in_ready;
            @(posedge clk); #1;
            budget++;
        end while (!acc && budget < 100);
        if (!acc) check("in_accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input int stall, input string nm);
        int budget;
        logic [7:0] d;
        logic v;
        bus.out_ready = 1'b0;
        budget = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid) break;
            budget++;
            if (budget > 100) begin
                check({nm, "_timeout"}, 32'd0, 32'd1);
                @(posedge clk); #1;
                return;
            end
        end
        @(posedge clk); #1;
        repeat (stall - 1) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        @(negedge clk); v = bus.out_valid; d = bus.out_data;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({nm, "_valid"}, v, 32'd1);
        check(nm, d, exp);
    endtask

    task automatic load_vector(input int n, output logic errx, output logic [15:0] res);
        logic [15:0] acc;
        acc  = 16'h0000;
        errx = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{vec_a[i], vec_b[i], (i == 0)});
            acc  = mac_fn(vec_a[i], vec_b[i], acc, (i == 0));
            errx = errx | (vec_a[i] == 16'hFFFF) | (vec_b[i] == 16'hFFFF);
        end
        res = (n == 0) ? 16'h0000 : acc;
        send_byte(8'(n), 1'b1);
        check("busy_after_hdr", bus.busy, 32'd1);
        check("err_cleared_by_hdr", bus.err, 32'd0);
        for (int i = 0; i < n; i++) begin
            send_byte(vec_a[i][15:8], 1'b1);
            send_byte(vec_a[i][7:0],  1'b1);
            send_byte(vec_b[i][15:8], 1'b1);
            send_byte(vec_b[i][7:0],  1'b1);
        end
    endtask

    task automatic run_vector(input int n, input bit use_lit, input logic [15:0] lit, input int stall);
        logic        errx;
        logic [15:0] res;
        load_vector(n, errx, res);
        // A pending byte offered while the result drains must not be taken.
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        recv_byte(res[15:8], stall, "res_hi");
        check("err_during_send", bus.err, errx);
        recv_byte(res[7:0], stall, "res_lo");
        bus.in_valid = 1'b0;
        check("err_after_send", bus.err, errx);
        check("busy_after_vec", bus.busy, 32'd0);
        check("all_pairs_issued", exp_q.size(), 32'd0);
        if (use_lit) check("model_result", res, lit);
    endtask

    function automatic logic [15:0] rand_op();
        if ($urandom_range(0, 11) == 0) return 16'hFFFF;
        return {1'($urandom_range(0, 1)), 6'($urandom_range(26, 36)), 9'($urandom_range(0, 511))};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic        errx;
        logic [15:0] res;
        int          n;

        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_in_ready", bus.in_ready, 32'd0);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_mac_ab", {bus.mac_a, bus.mac_b}, 32'd0);
        check("rst_mac_en_clr", {bus.mac_en, bus.mac_clr}, 32'd0);
        check("rst_busy_err", {bus.busy, bus.err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", bus.in_ready, 32'd1);
        check("idle_busy", bus.busy, 32'd0);

        // Hand-computed DLFloat16 values pin the MAC model.
        check("pin_1x1", mac_fn(16'h3E00, 16'h3E00, 16'h0000, 1'b1), 32'h3E00);
        check("pin_3p0", mac_fn(16'h3E00, 16'h3E00, mac_fn(16'h3E00, 16'h4000, 16'h1234, 1'b1), 1'b0), 32'h4100);
        @(posedge clk); #1;

        // 1.0 x 1.0
        vec_a[0] = 16'h3E00; vec_b[0] = 16'h3E00;
        run_vector(1, 1'b1, 16'h3E00, 2);

        // 1*2 + 1*1 = 3.0
        vec_a[0] = 16'h3E00; vec_b[0] = 16'h4000;
        vec_a[1] = 16'h3E00; vec_b[1] = 16'h3E00;
        run_vector(2, 1'b1, 16'h4100, 1);

        // Empty vector
        run_vector(0, 1'b1, 16'h0000, 1);

        // Bad operand sets err; the following header clears it
        vec_a[0] = 16'hFFFF; vec_b[0] = 16'h3E00;
        run_vector(1, 1'b0, 16'h0000, 1);
        check("err_set_lit", bus.err, 32'd1);

        // Long out_ready stall in both send states
        vec_a[0] = 16'h4000; vec_b[0] = 16'h4000;
        run_vector(1, 1'b1, 16'h4200, 5);

        // Randomized vectors
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                vec_a[i] = rand_op();
                vec_b[i] = rand_op();
            end
            run_vector(n, 1'b0, 16'h0000, $urandom_range(1, 4));
        end

        // Reset during DRAIN of a 3-element vector (third operand bad)
        vec_a[0] = 16'h3E00; vec_b[0] = 16'h4000;
        vec_a[1] = 16'h4000; vec_b[1] = 16'h4000;
        vec_a[2] = 16'hFFFF; vec_b[2] = 16'h3E00;
        load_vector(3, errx, res);
        @(posedge clk); #1;   // final ISSUE -> first DRAIN cycle
        check("drain_err_set", bus.err, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", bus.in_ready, 32'd0);
        check("arst_busy", bus.busy, 32'd0);
        check("arst_err", bus.err, 32'd0);
        check("arst_mac_ab", {bus.mac_a, bus.mac_b}, 32'd0);
        check("arst_out", {bus.out_valid, bus.out_data}, 32'd0);
        check("arst_pairs_done", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        check("arst_no_out", bus.out_valid, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vec_a[0] = 16'h3E00; vec_b[0] = 16'h4000;
        run_vector(1, 1'b1, 16'h4000, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
